hmc_tx_token_ctrl: RTL

- Flow-control gate in the TX path of the HMC controller, directly upstream of the TX link serializer.
- Tracks free slots in the HMC input buffer, which is sized by LOG_MAX_HMC_TOKENS.
- Grants FLIT transmission only when enough tokens remain, and replenishes tokens from RTC fields returned on the RX side.
- Flags token accounting errors for the register file.

---
 rtl/hmc_tx_token_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hmc_tx_token_ctrl.sv
// HMC TX token flow-control gate.
// Grants FLIT words against free input-buffer tokens and replenishes from RTC.
module hmc_tx_token_ctrl #(
   parameter int FPW                = 4,
   parameter int LOG_FPW            = 2,
   parameter int LOG_MAX_HMC_TOKENS = 10
) (
   input  logic                          clk,
   input  logic                          res_n,
   input  logic                          init_valid,
   input  logic [LOG_MAX_HMC_TOKENS:0]   init_tokens,
   input  logic                          clear_err,
   input  logic                          tx_req_valid,
   input  logic [LOG_FPW:0]              tx_req_flits,
   output logic                          tx_req_ready,
   input  logic                          rtc_valid,
   input  logic [LOG_MAX_HMC_TOKENS:0]   rtc_tokens,
   output logic [LOG_MAX_HMC_TOKENS:0]   tokens_avail,
   output logic [LOG_MAX_HMC_TOKENS:0]   tokens_max,
   output logic                          token_err,
   output logic                          state_active
);

   localparam int TW = LOG_MAX_HMC_TOKENS + 1;
   localparam logic [TW-1:0] TOK_LIM = TW'(1) << LOG_MAX_HMC_TOKENS;
   localparam logic [LOG_FPW:0] FPW_L = (LOG_FPW+1)'(FPW);

   typedef enum logic [1:0] {
      UNINIT,
      ACTIVE,
      ERROR
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [TW-1:0] avail_nx;
   logic [TW-1:0] max_nx;
   logic [TW-1:0] flits_ext;
   logic [TW:0]   sum;
   logic          flits_ok;
   logic          init_ok;
   logic          fire;

   assign flits_ext = TW'(tx_req_flits);
   assign flits_ok  = tx_req_flits <= FPW_L;
   assign init_ok   = (init_tokens != '0) && (init_tokens <= TOK_LIM);

   // Grant depends only on the registered count, never on same-cycle RTC.
   assign tx_req_ready = (state == ACTIVE) && flits_ok &&
                         (tokens_avail >= flits_ext);
   assign fire = tx_req_valid && tx_req_ready;

   // One extra bit so an RTC overflow is visible before the compare.
   assign sum = {1'b0, tokens_avail}
              - (fire ? {1'b0, flits_ext} : '0)
              + (rtc_valid ? {1'b0, rtc_tokens} : '0);

   // Next state and next counter values.
   always_comb begin
      state_nx = state;
      avail_nx = tokens_avail;
      max_nx   = tokens_max;
      unique case (state)
         UNINIT: begin
            if (init_valid) begin
               if (init_ok) begin
                  state_nx = ACTIVE;
                  avail_nx = init_tokens;
                  max_nx   = init_tokens;
               end else begin
                  state_nx = ERROR;
               end
            end
         end
         ACTIVE: begin
            if (init_valid) begin
               if (init_ok) begin
                  avail_nx = init_tokens;
                  max_nx   = init_tokens;
               end else begin
                  state_nx = ERROR;
               end
            end else if (tx_req_valid && !flits_ok) begin
               state_nx = ERROR;
            end else if (sum > {1'b0, tokens_max}) begin
               avail_nx = tokens_max;
               state_nx = ERROR;
            end else begin
               avail_nx = sum[TW-1:0];
            end
         end
         ERROR: begin
            if (clear_err) begin
               state_nx = UNINIT;
               avail_nx = '0;
            end
         end
         default: begin
            state_nx = UNINIT;
         end
      endcase
   end

   // State, counters and registered status flags.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state        <= UNINIT;
         tokens_avail <= '0;
         tokens_max   <= '0;
         token_err    <= 1'b0;
         state_active <= 1'b0;
      end else begin
         state        <= state_nx;
         tokens_avail <= avail_nx;
         tokens_max   <= max_nx;
         token_err    <= (state_nx == ERROR);
         state_active <= (state_nx == ACTIVE);
      end
   end

endmodule
